// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU micro-sequencer: FSM states, opcodes,
// ALU unit select codes and the registered control bundle.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCnt,
    StExec,
    StDone
  } state_e;

  typedef enum logic [2:0] {
    OpAdd = 3'd0,
    OpSub = 3'd1,
    OpAnd = 3'd2,
    OpOr  = 3'd3,
    OpXor = 3'd4,
    OpNot = 3'd5,
    OpShl = 3'd6,
    OpCmp = 3'd7
  } op_e;

  localparam logic [3:0] OUT_ADDSUB = 4'd5;
  localparam logic [3:0] OUT_ANDOR  = 4'd6;
  localparam logic [3:0] OUT_SHIFT  = 4'd7;
  localparam logic [3:0] OUT_XORNOT = 4'd10;
  localparam logic [3:0] CTL_IDLE   = 4'hF;
  localparam logic [2:0] ARG_R_ZERO = 3'd6;
  localparam logic [2:0] ARG_R_NONE = 3'd7;

  // Registered ALU controls; cin is kept out because it follows fout live.
  typedef struct packed {
    logic [3:0] outctl;
    logic [3:0] loadctl;
    logic [1:0] arg_l;
    logic [2:0] arg_r;
    logic       alt;
    logic       calcfn;
  } ctl_t;

  localparam ctl_t IDLE_CTL = '{
    outctl:  CTL_IDLE,
    loadctl: CTL_IDLE,
    arg_l:   2'd0,
    arg_r:   ARG_R_NONE,
    alt:     1'b0,
    calcfn:  1'b1
  };

  // A shift-count byte of 0 encodes eight cycles.
  function automatic logic [3:0] shift_count(input logic [2:0] count_bits);
    return (count_bits == 3'd0) ? 4'd8 : {1'b0, count_bits};
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational decode of one opcode (plus live carry flag) into the ALU
// control fields that apply while the instruction executes.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [2:0] i_op,
  input  logic [1:0] i_dst,
  input  logic [1:0] i_src,
  input  logic       i_c,
  input  logic [3:0] i_fout,
  output logic [3:0] o_outctl,
  output logic [3:0] o_loadctl,
  output logic [1:0] o_arg_l,
  output logic [2:0] o_arg_r,
  output logic       o_alt,
  output logic       o_cin
);

  op_e  w_op;
  logic w_carry;
  logic w_unused_flags;

  assign w_op           = op_e'(i_op);
  assign w_carry        = i_fout[0];
  assign w_unused_flags = ^i_fout[3:1];

  always_comb begin
    o_outctl  = OUT_ADDSUB;
    o_loadctl = {2'b00, i_dst};
    o_arg_l   = i_dst;
    o_arg_r   = {1'b0, i_src};
    o_alt     = 1'b0;
    o_cin     = 1'b0;
    unique case (w_op)
      OpAdd: begin
        o_outctl = OUT_ADDSUB;
        o_cin    = i_c & w_carry;
      end
      OpSub: begin
        o_outctl = OUT_ADDSUB;
        o_alt    = 1'b1;
        // Plain SUB feeds carry 1 (two's complement); SBC chains the borrow.
        o_cin    = i_c ? w_carry : 1'b1;
      end
      OpAnd: begin
        o_outctl = OUT_ANDOR;
      end
      OpOr: begin
        o_outctl = OUT_ANDOR;
        o_alt    = 1'b1;
      end
      OpXor: begin
        o_outctl = OUT_XORNOT;
      end
      OpNot: begin
        o_outctl = OUT_XORNOT;
        o_arg_r  = ARG_R_ZERO;
        o_alt    = 1'b1;
      end
      OpShl: begin
        o_outctl = OUT_SHIFT;
        o_arg_r  = ARG_R_NONE;
        o_cin    = i_c & w_carry;
      end
      OpCmp: begin
        o_outctl  = OUT_ADDSUB;
        o_loadctl = CTL_IDLE;
        o_alt     = 1'b1;
        o_cin     = 1'b1;
      end
      default: begin
        o_outctl = OUT_ADDSUB;
      end
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Micro-sequencer that turns an opcode byte (and an optional shift count byte)
// into one or more cycles of ALU control, followed by a done pulse.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ir_load,
  input  logic [7:0] bus_in,
  input  logic [3:0] fout,
  output logic [3:0] outctl,
  output logic [3:0] loadctl,
  output logic [1:0] arg_l,
  output logic [2:0] arg_r,
  output logic       alt,
  output logic       calcfn,
  output logic       cin,
  output logic       busy,
  output logic       done
);

  state_e     r_state;
  logic [7:0] r_opcode;
  logic [3:0] r_count;
  ctl_t       r_ctl;
  logic       r_busy;
  logic       r_done;

  logic [7:0] w_opc;
  op_e        w_op;
  ctl_t       w_exec_ctl;
  logic [3:0] w_dec_outctl;
  logic [3:0] w_dec_loadctl;
  logic [1:0] w_dec_arg_l;
  logic [2:0] w_dec_arg_r;
  logic       w_dec_alt;
  logic       w_dec_cin;

  // In IDLE the opcode is still on the bus; afterwards decode the held copy.
  assign w_opc = (r_state == StIdle) ? bus_in : r_opcode;
  assign w_op  = op_e'(w_opc[7:5]);

  alu_seq_decode u_decode (
    .i_op      (w_opc[7:5]),
    .i_dst     (w_opc[4:3]),
    .i_src     (w_opc[2:1]),
    .i_c       (w_opc[0]),
    .i_fout    (fout),
    .o_outctl  (w_dec_outctl),
    .o_loadctl (w_dec_loadctl),
    .o_arg_l   (w_dec_arg_l),
    .o_arg_r   (w_dec_arg_r),
    .o_alt     (w_dec_alt),
    .o_cin     (w_dec_cin)
  );

  assign w_exec_ctl = '{
    outctl:  w_dec_outctl,
    loadctl: w_dec_loadctl,
    arg_l:   w_dec_arg_l,
    arg_r:   w_dec_arg_r,
    alt:     w_dec_alt,
    calcfn:  1'b0
  };

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_opcode <= 8'd0;
      r_count  <= 4'd0;
      r_ctl    <= IDLE_CTL;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (ir_load) begin
            r_opcode <= bus_in;
            r_busy   <= 1'b1;
            if (w_op == OpShl) begin
              r_state <= StCnt;
            end else begin
              r_state <= StExec;
              r_ctl   <= w_exec_ctl;
            end
          end
        end
        StCnt: begin
          if (ir_load) begin
            r_count <= shift_count(bus_in[2:0]);
            r_state <= StExec;
            r_ctl   <= w_exec_ctl;
          end
        end
        StExec: begin
          // Shifts stay here until the count runs out; everything else leaves at once.
          if ((w_op == OpShl) && (r_count > 4'd1)) begin
            r_count <= r_count - 4'd1;
          end else begin
            if (w_op == OpShl) begin
              r_count <= 4'd0;
            end
            r_state <= StDone;
            r_ctl   <= IDLE_CTL;
            r_done  <= 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_ctl   <= IDLE_CTL;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign outctl  = r_ctl.outctl;
  assign loadctl = r_ctl.loadctl;
  assign arg_l   = r_ctl.arg_l;
  assign arg_r   = r_ctl.arg_r;
  assign alt     = r_ctl.alt;
  assign calcfn  = r_ctl.calcfn;
  // Carry-in follows the live flags so RCL chains through every shift cycle.
  assign cin     = (r_state == StExec) & w_dec_cin;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised scoreboard bench for alu_sequencer: stimulus queues expected
// EXEC cycles and done pulses with cycle stamps, a negedge monitor checks them.
module tb_alu_sequencer;

  logic       clk;
  logic       rst;
  logic       ir_load;
  logic [7:0] bus_in;
  logic [3:0] fout;
  logic [3:0] outctl;
  logic [3:0] loadctl;
  logic [1:0] arg_l;
  logic [2:0] arg_r;
  logic       alt;
  logic       calcfn;
  logic       cin;
  logic       busy;
  logic       done;

  alu_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .ir_load (ir_load),
    .bus_in  (bus_in),
    .fout    (fout),
    .outctl  (outctl),
    .loadctl (loadctl),
    .arg_l   (arg_l),
    .arg_r   (arg_r),
    .alt     (alt),
    .calcfn  (calcfn),
    .cin     (cin),
    .busy    (busy),
    .done    (done)
  );

  typedef struct {
    int         cyc;
    logic [3:0] outctl;
    logic [3:0] loadctl;
    logic [1:0] arg_l;
    logic [2:0] arg_r;
    logic       alt;
    logic       cin;
  } exp_t;

  exp_t exec_q[$];
  int   done_q[$];
  int   cyc       = 0;
  int   busy_from = 1;
  int   busy_to   = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: control fields straight from the opcode table.
  function automatic exp_t model(input logic [7:0] opc, input logic [3:0] f);
    exp_t       e;
    int         op;
    logic [1:0] dst;
    logic [1:0] src;
    logic       cb;
    op  = int'(opc[7:5]);
    dst = opc[4:3];
    src = opc[2:1];
    cb  = opc[0];
    e.cyc     = 0;
    e.arg_l   = dst;
    e.loadctl = (op == 7) ? 4'hF : {2'b00, dst};
    e.arg_r   = (op == 5) ? 3'd6 : (op == 6) ? 3'd7 : {1'b0, src};
    case (op)
      0, 1, 7: e.outctl = 4'd5;
      2, 3:    e.outctl = 4'd6;
      4, 5:    e.outctl = 4'd10;
      default: e.outctl = 4'd7;
    endcase
    e.alt = (op == 1) || (op == 3) || (op == 5) || (op == 7);
    case (op)
      0, 6:    e.cin = cb & f[0];
      1:       e.cin = cb ? f[0] : 1'b1;
      7:       e.cin = 1'b1;
      default: e.cin = 1'b0;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (cyc >= 1) begin
      chk("busy", {31'd0, busy}, {31'd0, (cyc >= busy_from) && (cyc <= busy_to)});
      if (calcfn === 1'b0) begin
        if (exec_q.size() == 0) begin
          chk("exec_unexpected", 32'd1, 32'd0);
        end else begin
          e = exec_q.pop_front();
          chk("exec_cycle", cyc, e.cyc);
          chk("outctl", {28'd0, outctl}, {28'd0, e.outctl});
          chk("loadctl", {28'd0, loadctl}, {28'd0, e.loadctl});
          chk("arg_l", {30'd0, arg_l}, {30'd0, e.arg_l});
          chk("arg_r", {29'd0, arg_r}, {29'd0, e.arg_r});
          chk("alt", {31'd0, alt}, {31'd0, e.alt});
          chk("cin", {31'd0, cin}, {31'd0, e.cin});
        end
      end else begin
        chk("idle_controls", {17'd0, outctl, loadctl, arg_l, arg_r, alt, cin, calcfn},
            {17'd0, 4'hF, 4'hF, 2'd0, 3'd7, 1'b0, 1'b0, 1'b1});
        while (exec_q.size() > 0 && exec_q[0].cyc <= cyc) begin
          e = exec_q.pop_front();
          chk("exec_missed", cyc, e.cyc);
        end
      end
      if (done === 1'b1) begin
        if (done_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
        else chk("done_cycle", cyc, done_q.pop_front());
      end else begin
        while (done_q.size() > 0 && done_q[0] <= cyc) begin
          chk("done_missed", cyc, 32'(done_q.pop_front()) + 32'd1000000);
        end
      end
    end
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ir_load = 1'b0;
      bus_in  = 8'($urandom);
      fout    = 4'($urandom);
    end
  endtask

  // fmode: 0 random flags, 1 fixed ffix, 2 ffix with bit 0 toggling per EXEC cycle.
  task automatic run_instr(input logic [7:0] opc, input logic [7:0] cnt_byte, input int fmode,
                           input logic [3:0] ffix, input int gap, input int abort);
    logic [3:0] fv[$];
    logic [3:0] f;
    int         k, m, n, nexec;
    bit         is_shl, do_abort;
    exp_t       e;
    @(posedge clk); #1;
    k       = cyc;
    ir_load = 1'b1;
    bus_in  = opc;
    fout    = 4'($urandom);
    is_shl  = (opc[7:5] == 3'd6);
    n       = is_shl ? ((cnt_byte[2:0] == 3'd0) ? 8 : int'(cnt_byte[2:0])) : 1;
    m       = is_shl ? k + 1 + gap : k;
    for (int i = 0; i < n; i++) begin
      if (fmode == 0) f = 4'($urandom);
      else if (fmode == 1) f = ffix;
      else f = {ffix[3:1], ffix[0] ^ i[0]};
      fv.push_back(f);
    end
    do_abort = (abort > 0) && (abort < n);
    nexec    = do_abort ? abort : n;
    for (int i = 0; i < nexec; i++) begin
      e     = model(opc, fv[i]);
      e.cyc = m + 1 + i;
      exec_q.push_back(e);
    end
    busy_from = k + 1;
    if (do_abort) begin
      busy_to = m + nexec;
    end else begin
      busy_to = m + n + 1;
      done_q.push_back(m + n + 1);
    end
    if (is_shl) begin
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        ir_load = 1'b0;
        bus_in  = 8'($urandom);
        fout    = 4'($urandom);
      end
      @(posedge clk); #1;
      ir_load = 1'b1;
      bus_in  = cnt_byte;
      fout    = 4'($urandom);
    end
    for (int i = 0; i < nexec; i++) begin
      @(posedge clk); #1;
      fout    = fv[i];
      ir_load = 1'($urandom);
      bus_in  = 8'($urandom);
      if (do_abort && i == nexec - 1) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst     = 1'b0;
    ir_load = do_abort ? 1'b0 : 1'($urandom);
    bus_in  = 8'($urandom);
    fout    = 4'($urandom);
    if (do_abort) ir_load = 1'b0;
  endtask

  initial begin
    logic [7:0] opc;
    rst     = 1'b1;
    ir_load = 1'b0;
    bus_in  = 8'd0;
    fout    = 4'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_cycles(2);

    run_instr(8'h0C, 8'h00, 0, 4'h0, 0, 0);
    run_instr(8'h0D, 8'h00, 1, 4'h1, 0, 0);
    run_instr(8'h2C, 8'h00, 1, 4'h0, 0, 0);
    run_instr(8'h2D, 8'h00, 1, 4'h0, 0, 0);
    run_instr(8'hC0, 8'h03, 0, 4'h0, 1, 0);
    run_instr(8'hC1, 8'h05, 2, 4'h1, 0, 0);
    run_instr(8'hF8, 8'h00, 0, 4'h0, 0, 0);
    run_instr(8'hC0, 8'h00, 0, 4'h0, 0, 2);
    idle_cycles(1);
    run_instr(8'hC1, 8'h00, 2, 4'h0, 2, 0);

    for (int i = 0; i < 200; i++) begin
      opc = 8'($urandom);
      if ((i % 3) == 0) opc[7:5] = 3'd6;
      run_instr(opc, 8'($urandom), 0, 4'h0, $urandom_range(0, 2),
                ((i % 16) == 5) ? $urandom_range(1, 4) : 0);
      idle_cycles($urandom_range(0, 2));
    end

    idle_cycles(3);
    chk("exec_queue_drained", exec_q.size(), 32'd0);
    chk("done_queue_drained", done_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Ports SHALL be as follows; clock and reset SHALL come first.
REQ-002 One clock; reset is synchronous and active-high.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- ir_load  in  1  strobe: capture bus_in as opcode (IDLE) or shift count (CNT).
- bus_in  in  8  opcode or count byte.
- fout  in  4  ALU flags: [0]=C, [1]=Z, [2]=V, [3]=N.
- outctl  out  4  ALU output-unit select.
- loadctl  out  4  ALU load-target select.
- arg_l  out  2  left operand register.
- arg_r  out  3  right operand register; 6 selects the zero source.
- alt  out  1  alternate function of the selected unit.
- calcfn  out  1  flag update, active-low.
- cin  out  1  carry into the ALU.
- busy  out  1  high while an instruction is in progress.
- done  out  1  one-cycle completion pulse.

Function
REQ-003 The opcode format SHALL be [7:5]=op, [4:3]=dst (also left operand), [2:1]=src, [0]=c.
REQ-004 Ops SHALL be 0 ADD/ADC, 1 SUB/SBC, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL/RCL, 7 CMP.
REQ-005 Idle controls SHALL be: outctl=F, loadctl=F, arg_l=0, arg_r=7, alt=0, cin=0, calcfn=1.
REQ-006 FSM states SHALL be IDLE, CNT, EXEC and DONE.
REQ-007 IDLE with ir_load SHALL capture the opcode and go to CNT for op 6, otherwise to EXEC.
REQ-008 CNT SHALL hold idle controls until ir_load, then capture bus_in[2:0] as the count (0 means 8) and go to EXEC.
REQ-009 EXEC SHALL last 1 cycle for ops 0-5 and 7, and exactly count cycles for op 6, then go to DONE.
REQ-010 DONE SHALL drive idle controls, pulse done=1 for one cycle, and return to IDLE.
REQ-011 busy SHALL be 1 in CNT, EXEC and DONE.
REQ-012 ir_load SHALL be ignored in EXEC and DONE.
REQ-013 In EXEC: arg_l=dst, calcfn=0, and loadctl=dst except for CMP, where loadctl=F.
REQ-014 outctl in EXEC: ADD/SUB/CMP=5, AND/OR=6, XOR/NOT=10, SHL=7.
REQ-015 arg_r in EXEC: src, except NOT=6 and SHL=7.
REQ-016 alt in EXEC SHALL be 1 for SUB, CMP, OR and NOT, and 0 otherwise.
REQ-017 cin in EXEC: ADD = c&fout[0]; SUB = c ? fout[0] : 1; CMP = 1; SHL = c&fout[0], re-sampled every cycle; all others = 0.
REQ-018 The latency for ops 0-5 and 7 SHALL be: ir_load at cycle t, EXEC at t+1, done at t+2, idle at t+3.

Reset
REQ-019 rst SHALL force IDLE, idle controls, busy=0 and done=0 on the next edge, including mid-operation, with no done pulse.
REQ-020 rst SHALL clear the opcode and count registers to 0.

Structure
REQ-021 The shared package alu_seq_pkg SHALL hold the state enum, the op enum, the unit codes (OUT_ADDSUB=5, OUT_ANDOR=6, OUT_SHIFT=7, OUT_XORNOT=10), CTL_IDLE=F, ARG_R_ZERO=6 and ARG_R_NONE=7.
REQ-022 One combinational sub-module, alu_seq_decode, SHALL map (op, dst, src, c, fout) to the EXEC control fields; the FSM and counters SHALL live in alu_sequencer.

Verification
REQ-023 Reset: rst for 1 cycle -> outctl=F, loadctl=F, arg_r=7, calcfn=1, busy=0, done=0.
REQ-024 ADD: 0x0C -> EXEC outctl=5, loadctl=1, arg_l=1, arg_r=2, alt=0, cin=0, calcfn=0; done at t+2; busy=0 at t+3.
REQ-025 Carry: ADC 0x0D with fout=1 -> cin=1; SUB 0x2C -> alt=1, cin=1; SBC 0x2D with fout=0 -> cin=0.
REQ-026 Shift: 0xC0 then count 0x03 -> three EXEC cycles with outctl=7, loadctl=0, arg_r=7, then done.
REQ-027 RCL: 0xC1 with fout[0] toggling -> cin tracks fout[0] each cycle.
REQ-028 CMP: 0xF8 -> outctl=5, loadctl=F, arg_l=3, arg_r=0, alt=1, cin=1, calcfn=0.
REQ-029 Reset mid-shift: count 0x00, rst after 2 EXEC cycles -> idle next cycle and no done.
REQ-030 ir_load pulsed during EXEC -> no effect on controls or the count.
